// File: rtl/coeff_pkg.sv
// Shared constants and FSM state type for the MSDAP coefficient and data stores.
package coeff_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int DEPTH_DEF    = 512;
    localparam int CHANNELS_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } coeff_state_e;

    // Select width that stays legal for a single-channel build.
    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/coeff_bank_if.sv
// Load handshake and FIR read port of the coefficient bank.
interface coeff_bank_if
    import coeff_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = $clog2(DEPTH_DEF),
    parameter int CH_W   = ch_width(CHANNELS_DEF)
);
    logic              load_start;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              load_done;
    logic              rd_en;
    logic [CH_W-1:0]   rd_chan;
    logic [ADDR_W:0]   rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_oor;

    modport master (
        output load_start, wr_valid, wr_data, rd_en, rd_chan, rd_addr,
        input  wr_ready, load_done, rd_data, rd_valid, rd_oor
    );

    modport slave (
        input  load_start, wr_valid, wr_data, rd_en, rd_chan, rd_addr,
        output wr_ready, load_done, rd_data, rd_valid, rd_oor
    );
endinterface

// File: rtl/coeff_ram.sv
// Flat CHANNELS x DEPTH single-write, registered-read RAM (read-before-write).
module coeff_ram
    import coeff_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int CHANNELS = CHANNELS_DEF,
    localparam int WORDS   = CHANNELS * DEPTH,
    localparam int FLAT_W  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [FLAT_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic              clr_i,
    input  logic [FLAT_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] rdata_q;

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register: clr forces zero for rejected reads, otherwise holds.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= {DATA_W{1'b0}};
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end else if (clr_i) begin
            rdata_q <= {DATA_W{1'b0}};
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/coeff_bank.sv
// Multi-channel coefficient bank: sequential loader FSM plus range-checked
// one-cycle read port for the FIR engine.
module coeff_bank
    import coeff_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int CH_W     = ch_width(CHANNELS)
) (
    input  logic         Sclk,
    input  logic         Reset,
    coeff_bank_if.slave  bus
);
    localparam int WORDS  = CHANNELS * DEPTH;
    localparam int FLAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    coeff_state_e      state_q, state_d;
    logic [CH_W-1:0]   wr_chan_q, wr_chan_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              load_done_q, load_done_d;
    logic              rd_valid_q, rd_oor_q;

    logic              wr_ready_s, wr_accept_s, rd_in_range_s;
    logic [FLAT_W-1:0] wr_flat_s, rd_flat_s;

    // Loader next state; load_start pre-empts every state and blocks acceptance.
    always_comb begin
        state_d     = state_q;
        wr_chan_d   = wr_chan_q;
        wr_addr_d   = wr_addr_q;
        load_done_d = load_done_q;
        wr_ready_s  = 1'b0;
        wr_accept_s = 1'b0;
        if (bus.load_start) begin
            state_d     = LOAD;
            wr_chan_d   = {CH_W{1'b0}};
            wr_addr_d   = {ADDR_W{1'b0}};
            load_done_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                LOAD: begin
                    wr_ready_s  = 1'b1;
                    wr_accept_s = bus.wr_valid;
                    if (bus.wr_valid) begin
                        if (wr_addr_q == ADDR_W'(DEPTH - 1)) begin
                            wr_addr_d = {ADDR_W{1'b0}};
                            if (wr_chan_q == CH_W'(CHANNELS - 1)) begin
                                state_d     = DONE;
                                load_done_d = 1'b1;
                            end else begin
                                wr_chan_d = wr_chan_q + CH_W'(1);
                            end
                        end else begin
                            wr_addr_d = wr_addr_q + ADDR_W'(1);
                        end
                    end else begin
                        wr_addr_d = wr_addr_q;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Loader state and counters.
    always_ff @(posedge Sclk) begin
        if (Reset) begin
            state_q     <= IDLE;
            wr_chan_q   <= {CH_W{1'b0}};
            wr_addr_q   <= {ADDR_W{1'b0}};
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_chan_q   <= wr_chan_d;
            wr_addr_q   <= wr_addr_d;
            load_done_q <= load_done_d;
        end
    end

    assign rd_in_range_s = (bus.rd_addr < (ADDR_W + 1)'(DEPTH)) &&
                           ({1'b0, bus.rd_chan} < (CH_W + 1)'(CHANNELS));
    assign wr_flat_s = FLAT_W'(wr_chan_q) * FLAT_W'(DEPTH) + FLAT_W'(wr_addr_q);
    assign rd_flat_s = FLAT_W'(bus.rd_chan) * FLAT_W'(DEPTH) +
                       FLAT_W'(bus.rd_addr[ADDR_W-1:0]);

    // Read status; rd_oor describes the most recent read and holds between reads.
    always_ff @(posedge Sclk) begin
        if (Reset) begin
            rd_valid_q <= 1'b0;
            rd_oor_q   <= 1'b0;
        end else if (bus.rd_en) begin
            rd_valid_q <= 1'b1;
            rd_oor_q   <= !rd_in_range_s;
        end else begin
            rd_valid_q <= 1'b0;
            rd_oor_q   <= rd_oor_q;
        end
    end

    coeff_ram #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .CHANNELS (CHANNELS)
    ) u_ram (
        .clk_i   (Sclk),
        .rst_i   (Reset),
        .we_i    (wr_accept_s && !Reset),
        .waddr_i (wr_flat_s),
        .wdata_i (bus.wr_data),
        .re_i    (bus.rd_en && rd_in_range_s),
        .clr_i   (bus.rd_en && !rd_in_range_s),
        .raddr_i (rd_flat_s),
        .rdata_o (bus.rd_data)
    );

    assign bus.wr_ready  = wr_ready_s;
    assign bus.load_done = load_done_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_oor    = rd_oor_q;
endmodule

// File: tb/tb_coeff_bank.sv
// Directed self-checking bench for coeff_bank (DEPTH=512, 2 channels, plus a 3-channel build).
module tb_coeff_bank;
    import coeff_pkg::*;

    localparam int DW  = 16;
    localparam int DEP = 512;
    localparam int AW  = 9;
    localparam int CW  = 1;
    localparam int CW3 = 2;

    typedef struct {
        logic        rd_en;
        int          ch;
        int          addr;
        logic [15:0] data;
        logic        valid;
        logic        oor;
    } rvec_t;

    logic Sclk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    always #5 Sclk = ~Sclk;

    coeff_bank_if #(.DATA_W(DW), .ADDR_W(AW), .CH_W(CW))  bus ();
    coeff_bank_if #(.DATA_W(DW), .ADDR_W(AW), .CH_W(CW3)) bus3 ();

    coeff_bank #(.DATA_W(DW), .DEPTH(DEP), .CHANNELS(2)) dut (
        .Sclk (Sclk), .Reset (Reset), .bus (bus)
    );

    coeff_bank #(.DATA_W(DW), .DEPTH(DEP), .CHANNELS(3)) dut3 (
        .Sclk (Sclk), .Reset (Reset), .bus (bus3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Sclk);
        #1;
    endtask

    task automatic rd(input string nm, input int ch, input int addr, input logic [15:0] exp);
        bus.rd_en   = 1'b1;
        bus.rd_chan = CW'(ch);
        bus.rd_addr = (AW + 1)'(addr);
        step();
        bus.rd_en = 1'b0;
        chk({nm, "_data"}, 32'(bus.rd_data), 32'(exp));
        chk({nm, "_valid"}, 32'(bus.rd_valid), 32'd1);
        chk({nm, "_oor"}, 32'(bus.rd_oor), 32'd0);
    endtask

    rvec_t tbl [10];
    int    acc;
    logic  v;

    initial begin
        tbl[0] = '{1'b1, 1, 5,    16'h1205, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 0, 0,    16'h1000, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 0, 511,  16'h11FF, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1, 0,    16'h1200, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1, 511,  16'h13FF, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 0, 512,  16'h0000, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 0, 0,    16'h0000, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1, 1023, 16'h0000, 1'b1, 1'b1};
        tbl[8] = '{1'b1, 0, 100,  16'h1064, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1, 7,    16'h1064, 1'b0, 1'b0};

        bus.load_start  = 1'b0; bus.wr_valid  = 1'b0; bus.wr_data  = 16'h0000;
        bus.rd_en       = 1'b0; bus.rd_chan   = 1'b0;  bus.rd_addr  = 10'd0;
        bus3.load_start = 1'b0; bus3.wr_valid = 1'b0; bus3.wr_data = 16'h0000;
        bus3.rd_en      = 1'b0; bus3.rd_chan  = 2'd0;  bus3.rd_addr = 10'd0;

        // Reset values
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        #1;
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("rst_load_done", 32'(bus.load_done), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_oor", 32'(bus.rd_oor), 32'd0);

        // Full continuous load of 0x1000+i
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        #1;
        chk("first_load_wr_ready", 32'(bus.wr_ready), 32'd1);
        for (int i = 0; i < 1024; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 16'(32'h1000 + i);
            if (i == 1023) chk("done_before_last", 32'(bus.load_done), 32'd0);
            step();
        end
        chk("done_after_last", 32'(bus.load_done), 32'd1);
        bus.wr_data = 16'hDEAD;
        #1;
        chk("done_wr_ready", 32'(bus.wr_ready), 32'd0);
        step();
        step();
        bus.wr_valid = 1'b0;
        chk("done_level", 32'(bus.load_done), 32'd1);

        // Table-driven read-back and range checks
        for (int k = 0; k < 10; k++) begin
            bus.rd_en   = tbl[k].rd_en;
            bus.rd_chan = CW'(tbl[k].ch);
            bus.rd_addr = (AW + 1)'(tbl[k].addr);
            step();
            bus.rd_en = 1'b0;
            chk($sformatf("tbl%0d_data", k), 32'(bus.rd_data), 32'(tbl[k].data));
            chk($sformatf("tbl%0d_valid", k), 32'(bus.rd_valid), 32'(tbl[k].valid));
            chk($sformatf("tbl%0d_oor", k), 32'(bus.rd_oor), 32'(tbl[k].oor));
        end

        // Partial stalled load, restart at word 300, then stalled full load
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        acc = 0;
        for (int c = 0; c < 2000 && acc < 300; c++) begin
            bus.wr_valid = (c % 4 == 0) || (c % 4 == 3);
            bus.wr_data  = 16'(32'h2000 + acc);
            #1;
            if (bus.wr_valid && bus.wr_ready) acc++;
            step();
        end
        bus.load_start = 1'b1;
        bus.wr_valid   = 1'b1;
        bus.wr_data    = 16'h0BAD;
        #1;
        chk("restart_wr_ready", 32'(bus.wr_ready), 32'd0);
        step();
        bus.load_start = 1'b0;
        chk("restart_done_low", 32'(bus.load_done), 32'd0);
        acc = 0;
        for (int c = 0; c < 6000 && acc < 1024; c++) begin
            v = (c < 400) ? ((c % 4 == 0) || (c % 4 == 3)) : ($urandom_range(0, 2) != 0);
            bus.wr_valid = v;
            bus.wr_data  = 16'(32'h3000 + acc);
            #1;
            if (v && bus.wr_ready) begin
                if (acc == 1023) chk("stall_done_before_last", 32'(bus.load_done), 32'd0);
                acc++;
            end
            step();
        end
        bus.wr_valid = 1'b0;
        chk("stall_accepts", 32'(acc), 32'd1024);
        chk("stall_done", 32'(bus.load_done), 32'd1);
        rd("stall_c0_511", 0, 511, 16'h31FF);
        rd("stall_c0_0", 0, 0, 16'h3000);
        rd("stall_c0_300", 0, 300, 16'h312C);
        rd("stall_c1_511", 1, 511, 16'h33FF);

        // Same-edge read/write collision at (0,7)
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 16'(32'h4000 + i);
            if (i == 7) begin
                bus.rd_en   = 1'b1;
                bus.rd_chan = 1'b0;
                bus.rd_addr = 10'd7;
            end
            step();
        end
        bus.rd_en    = 1'b0;
        bus.wr_valid = 1'b0;
        chk("collision_old", 32'(bus.rd_data), 32'h3007);
        rd("collision_new", 0, 7, 16'h4007);

        // Reset at word 600 of a load
        for (int i = 8; i < 600; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 16'(32'h4000 + i);
            step();
        end
        Reset        = 1'b1;
        bus.rd_en    = 1'b1;
        bus.rd_chan  = 1'b0;
        bus.rd_addr  = 10'd1;
        bus.wr_data  = 16'h5555;
        step();
        Reset        = 1'b0;
        bus.rd_en    = 1'b0;
        bus.wr_data  = 16'hEEEE;
        #1;
        chk("rstmid_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("rstmid_done", 32'(bus.load_done), 32'd0);
        chk("rstmid_rd_valid", 32'(bus.rd_valid), 32'd0);
        step();
        step();
        step();
        bus.wr_valid = 1'b0;
        chk("idle_done", 32'(bus.load_done), 32'd0);
        rd("rstmid_word600", 1, 88, 16'h3258);
        rd("rstmid_word599", 1, 87, 16'h4257);
        rd("idle_no_write", 0, 0, 16'h4000);

        // Channel range check on the 3-channel build
        bus3.rd_en   = 1'b1;
        bus3.rd_chan = 2'd3;
        bus3.rd_addr = 10'd0;
        step();
        chk("ch3_oor", 32'(bus3.rd_oor), 32'd1);
        chk("ch3_data", 32'(bus3.rd_data), 32'd0);
        chk("ch3_valid", 32'(bus3.rd_valid), 32'd1);
        bus3.rd_chan = 2'd2;
        bus3.rd_addr = 10'd511;
        step();
        chk("ch2_in_range", 32'(bus3.rd_oor), 32'd0);
        bus3.rd_addr = 10'd512;
        step();
        bus3.rd_en = 1'b0;
        chk("ch2_addr_oor", 32'(bus3.rd_oor), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
